// File: rtl/generic_dispatch_queue_pkg.sv
// Shared backend types for the dispatch queue: rob tag layout and the
// age comparison used when a redirect flushes younger entries.
package generic_dispatch_queue_pkg;

   localparam int unsigned ROB_IDX_W = 6;

   typedef struct packed {
      logic                 dir;
      logic [ROB_IDX_W-1:0] idx;
   } rob_tag_t;

   // Index arguments are widened so any ROB_WIDTH can share one comparator.
   function automatic logic rob_younger(input logic        x_dir,
                                        input logic [31:0] x_idx,
                                        input logic        r_dir,
                                        input logic [31:0] r_idx);
      return (x_dir == r_dir) ? (x_idx > r_idx) : (x_idx < r_idx);
   endfunction

endpackage

// File: rtl/generic_dispatch_queue_if.sv
// Enqueue/dequeue/redirect bundle of the dispatch queue; the producer and
// consumer side are the master, the queue itself is the slave.
interface generic_dispatch_queue_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned IN_WIDTH   = 4,
   parameter int unsigned OUT_WIDTH  = 2,
   parameter int unsigned PREG_WIDTH = 7,
   parameter int unsigned ROB_WIDTH  = 6
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned TW = $clog2(OUT_WIDTH + 1);
   localparam int unsigned RW = ROB_WIDTH + 1;

   logic [IN_WIDTH-1:0]            enq_valid;
   logic [IN_WIDTH*PREG_WIDTH-1:0] enq_rs1;
   logic [IN_WIDTH*PREG_WIDTH-1:0] enq_rs2;
   logic [IN_WIDTH*RW-1:0]         enq_rob;
   logic [IN_WIDTH*DATA_WIDTH-1:0] enq_data;
   logic                           stall;
   logic                           full;

   logic [OUT_WIDTH-1:0]            deq_valid;
   logic [OUT_WIDTH*PREG_WIDTH-1:0] deq_rs1;
   logic [OUT_WIDTH*PREG_WIDTH-1:0] deq_rs2;
   logic [OUT_WIDTH*RW-1:0]         deq_rob;
   logic [OUT_WIDTH*DATA_WIDTH-1:0] deq_data;
   logic [TW-1:0]                   deq_take;

   logic          redirect;
   logic [RW-1:0] redirect_rob;
   logic [CW-1:0] count;

   modport master (
      output enq_valid, enq_rs1, enq_rs2, enq_rob, enq_data, stall,
      output deq_take, redirect, redirect_rob,
      input  full, deq_valid, deq_rs1, deq_rs2, deq_rob, deq_data, count
   );

   modport slave (
      input  enq_valid, enq_rs1, enq_rs2, enq_rob, enq_data, stall,
      input  deq_take, redirect, redirect_rob,
      output full, deq_valid, deq_rs1, deq_rs2, deq_rob, deq_data, count
   );

endinterface

// File: rtl/generic_dispatch_queue_valid_prefix_count.sv
// Exclusive prefix counts of a valid vector: count_o[i] is the number of set
// bits below i, and count_o[N] is the full popcount.
module valid_prefix_count #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = $clog2(N + 1)
) (
   input  logic [N-1:0]         valid_i,
   output logic [N:0][CW-1:0]   count_o
);

   logic [CW-1:0] acc;

   always_comb begin
      acc     = '0;
      count_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         count_o[i] = acc;
         acc        = acc + CW'(valid_i[i]);
      end
      count_o[N] = acc;
   end

endmodule

// File: rtl/generic_dispatch_queue.sv
// Multi-lane in-order dispatch queue with compacting enqueue, partial
// dequeue and rob-tag based flush of younger entries on redirect.
module generic_dispatch_queue
   import generic_dispatch_queue_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned IN_WIDTH   = 4,
   parameter int unsigned OUT_WIDTH  = 2,
   parameter int unsigned PREG_WIDTH = 7,
   parameter int unsigned ROB_WIDTH  = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   generic_dispatch_queue_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned IW = $clog2(IN_WIDTH + 1);
   localparam int unsigned RW = ROB_WIDTH + 1;

   typedef struct packed {
      logic [PREG_WIDTH-1:0] rs1;
      logic [PREG_WIDTH-1:0] rs2;
      logic [RW-1:0]         rob;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t                 mem_q [DEPTH];
   logic [PW-1:0]          head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [IN_WIDTH:0][IW-1:0] enq_cnt;
   logic [DEPTH-1:0]       keep;
   logic [DEPTH:0][PW-1:0] keep_cnt;
   logic [PW-1:0]          survivors;
   logic [31:0]            add, nvalid, take, sub;
   logic                   full, fire;

   valid_prefix_count #(.N(IN_WIDTH)) u_enq_cnt (
      .valid_i (bus.enq_valid),
      .count_o (enq_cnt)
   );

   valid_prefix_count #(.N(DEPTH)) u_keep_cnt (
      .valid_i (keep),
      .count_o (keep_cnt)
   );

   // Survivors are the longest run from head whose prefix count equals its
   // position, which also stays correct if a stray older tag sits behind a flush.
   always_comb begin
      keep      = '0;
      survivors = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         keep[k] = (k < 32'(count_q)) &&
                   !rob_younger(mem_q[head_q[AW-1:0] + AW'(k)].rob[RW-1],
                                32'(mem_q[head_q[AW-1:0] + AW'(k)].rob[ROB_WIDTH-1:0]),
                                bus.redirect_rob[RW-1],
                                32'(bus.redirect_rob[ROB_WIDTH-1:0]));
      end
      for (int unsigned k = 0; k <= DEPTH; k++) begin
         if (32'(keep_cnt[k]) == k) survivors = PW'(k);
      end
   end

   always_comb begin
      add    = 32'(enq_cnt[IN_WIDTH]);
      full   = (32'(count_q) + add) > DEPTH;
      fire   = !bus.stall && !full && !bus.redirect;
      nvalid = bus.redirect ? '0 : ((32'(count_q) > OUT_WIDTH) ? OUT_WIDTH : 32'(count_q));
      take   = 32'(bus.deq_take);
      sub    = (take < nvalid) ? take : nvalid;

      if (bus.redirect) begin
         head_d  = head_q;
         tail_d  = head_q + survivors;
         count_d = survivors;
      end else begin
         head_d  = head_q + PW'(sub);
         tail_d  = tail_q + (fire ? PW'(add) : '0);
         count_d = count_q + (fire ? PW'(add) : '0) - PW'(sub);
      end
   end

   always_comb begin
      bus.full      = full;
      bus.count     = count_q;
      bus.deq_valid = '0;
      bus.deq_rs1   = '0;
      bus.deq_rs2   = '0;
      bus.deq_rob   = '0;
      bus.deq_data  = '0;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
         bus.deq_valid[i] = (32'(count_q) > i) && !bus.redirect;
         bus.deq_rs1[i*PREG_WIDTH +: PREG_WIDTH]  = mem_q[head_q[AW-1:0] + AW'(i)].rs1;
         bus.deq_rs2[i*PREG_WIDTH +: PREG_WIDTH]  = mem_q[head_q[AW-1:0] + AW'(i)].rs2;
         bus.deq_rob[i*RW +: RW]                  = mem_q[head_q[AW-1:0] + AW'(i)].rob;
         bus.deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_q[AW-1:0] + AW'(i)].data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fire) begin
         for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (bus.enq_valid[i]) begin
               mem_q[tail_q[AW-1:0] + AW'(enq_cnt[i])] <= '{
                  rs1:  bus.enq_rs1[i*PREG_WIDTH +: PREG_WIDTH],
                  rs2:  bus.enq_rs2[i*PREG_WIDTH +: PREG_WIDTH],
                  rob:  bus.enq_rob[i*RW +: RW],
                  data: bus.enq_data[i*DATA_WIDTH +: DATA_WIDTH]
               };
            end
         end
      end
   end

endmodule
